// File: rtl/matrix_pkg.sv
// Shared geometry, FSM state encoding and constants for the LED matrix scan controller.
// No logic here; latency/backpressure are properties of the modules that import it.
package matrix_pkg;
    localparam int NCOL  = 5;
    localparam int NROW  = 7;
    localparam int COL_W = 3;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOL - 1);
    localparam logic [NCOL-1:0]  GND_OFF  = '1;
    localparam logic [NCOL-1:0]  GND_ONE  = NCOL'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } scan_state_e;
endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Frame-producer/pin-side bundle of the scan controller: buffer writes, swap handshake, matrix pins.
// Pure wiring; master is the frame producer, slave is the scan controller.
interface matrix_scan_ctrl_if;
    import matrix_pkg::*;

    logic             enable;
    logic             wr_en;
    logic [COL_W-1:0] wr_col;
    logic [NROW-1:0]  wr_data;
    logic             swap_req;
    logic             swap_ack;
    logic             frame_start;
    logic [NCOL-1:0]  gnd;
    logic [NROW-1:0]  row;

    modport master (
        output enable, wr_en, wr_col, wr_data, swap_req,
        input  swap_ack, frame_start, gnd, row
    );

    modport slave (
        input  enable, wr_en, wr_col, wr_data, swap_req,
        output swap_ack, frame_start, gnd, row
    );
endinterface

// File: rtl/matrix_fbuf.sv
// Double-buffered NCOL x NROW frame store: one write port into the back bank, combinational front read.
// Writes land at the clock edge with no backpressure; out-of-range columns are dropped.
module matrix_fbuf
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_fsel,
    input  logic             i_wr_en,
    input  logic [COL_W-1:0] i_wr_col,
    input  logic [NROW-1:0]  i_wr_data,
    input  logic [COL_W-1:0] i_rd_col,
    output logic [NROW-1:0]  o_rd_data
);
    logic [NROW-1:0] r_bank [2][NCOL];

    // The back bank is always the one not selected by i_fsel at this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NCOL; c++) begin
                    r_bank[b][c] <= '0;
                end
            end
        end else if (i_wr_en && (i_wr_col <= LAST_COL)) begin
            r_bank[~i_fsel][i_wr_col] <= i_wr_data;
        end
    end

    assign o_rd_data = (i_rd_col <= LAST_COL) ? r_bank[i_fsel][i_rd_col] : '0;
endmodule

// File: rtl/matrix_scan_ctrl.sv
// Paced column scan of the LED matrix with blanking and frame-boundary buffer swap.
// All outputs registered (one cycle after the deciding edge); no backpressure, enable low idles the scan.
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    matrix_scan_ctrl_if.slave bus
);
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

    scan_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic             r_fsel, w_fsel_nxt;
    logic             r_swap_pend, w_swap_pend_nxt;
    logic             r_swap_ack, w_swap_ack_nxt;
    logic             r_frame_start, w_frame_start_nxt;
    logic [NCOL-1:0]  r_gnd, w_gnd_nxt;
    logic [NROW-1:0]  r_row, w_row_nxt;
    logic [NROW-1:0]  w_front_dat;

    matrix_fbuf u_fbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_fsel    (r_fsel),
        .i_wr_en   (bus.wr_en),
        .i_wr_col  (bus.wr_col),
        .i_wr_data (bus.wr_data),
        .i_rd_col  (w_col_nxt),
        .o_rd_data (w_front_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_col         <= '0;
            r_fsel        <= 1'b0;
            r_swap_pend   <= 1'b0;
            r_swap_ack    <= 1'b0;
            r_frame_start <= 1'b0;
            r_gnd         <= GND_OFF;
            r_row         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_col         <= w_col_nxt;
            r_fsel        <= w_fsel_nxt;
            r_swap_pend   <= w_swap_pend_nxt;
            r_swap_ack    <= w_swap_ack_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_gnd         <= w_gnd_nxt;
            r_row         <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_col_nxt         = r_col;
        w_fsel_nxt        = r_fsel;
        w_swap_pend_nxt   = r_swap_pend | bus.swap_req;
        w_swap_ack_nxt    = 1'b0;
        w_frame_start_nxt = 1'b0;

        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_col_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt       = ST_BLANK;
                    w_cnt_nxt         = '0;
                    w_col_nxt         = '0;
                    w_frame_start_nxt = 1'b1;
                end
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = ST_DRIVE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == DWELL_LAST) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = '0;
                        if (r_col == LAST_COL) begin
                            // Frame boundary: a request arriving on this very edge waits for the next frame.
                            w_col_nxt         = '0;
                            w_frame_start_nxt = 1'b1;
                            if (r_swap_pend) begin
                                w_fsel_nxt      = ~r_fsel;
                                w_swap_pend_nxt = bus.swap_req;
                                w_swap_ack_nxt  = 1'b1;
                            end
                        end else begin
                            w_col_nxt = r_col + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode kept separate so the front-buffer read does not loop back into the FSM block.
    always_comb begin
        w_gnd_nxt = GND_OFF;
        w_row_nxt = '0;
        if (w_state_nxt == ST_DRIVE) begin
            w_gnd_nxt = ~(GND_ONE << w_col_nxt);
            w_row_nxt = w_front_dat;
        end
    end

    assign bus.gnd         = r_gnd;
    assign bus.row         = r_row;
    assign bus.frame_start = r_frame_start;
    assign bus.swap_ack    = r_swap_ack;
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: a time-based reference model predicts every output cycle.
module tb_matrix_scan_ctrl;
    import matrix_pkg::*;

    localparam int DW = 4;
    localparam int BL = 2;
    localparam int P  = DW + BL;
    localparam int F  = NCOL * P;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_scan_ctrl_if bus ();

    matrix_scan_ctrl #(.DWELL(DW), .BLANK(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [NCOL-1:0] gnd;
        logic [NROW-1:0] row;
        logic            fs;
        logic            ack;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: scan position is derived from cycles elapsed since the scan started.
    logic [NROW-1:0] m_buf [2][NCOL];
    int   m_fsel, m_pend, m_run, m_t;
    exp_t m_cur;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < NCOL; c++)
                m_buf[b][c] = '0;
        m_fsel = 0;
        m_pend = 0;
        m_run  = 0;
        m_t    = 0;
    endfunction

    function automatic exp_t model_edge(logic en, logic we, logic [COL_W-1:0] wc,
                                        logic [NROW-1:0] wd, logic sr);
        exp_t e;
        int   ph, c, w;
        bit   bnd;
        bnd = (m_run != 0) && en && ((m_t % F) == F - 1);
        if (we && int'(wc) < NCOL) m_buf[1 - m_fsel][wc] = wd;
        e.ack = 1'b0;
        if (bnd && m_pend != 0) begin
            m_fsel = 1 - m_fsel;
            m_pend = sr ? 1 : 0;
            e.ack  = 1'b1;
        end else if (sr) begin
            m_pend = 1;
        end
        if (!en) m_run = 0;
        else if (m_run == 0) begin m_run = 1; m_t = 0; end
        else m_t++;
        e.gnd = '1;
        e.row = '0;
        e.fs  = 1'b0;
        if (m_run != 0) begin
            ph   = m_t % F;
            c    = ph / P;
            w    = ph % P;
            e.fs = (ph == 0);
            if (w >= BL) begin
                e.gnd = ~(NCOL'(1) << c);
                e.row = m_buf[m_fsel][c];
            end
        end
        return e;
    endfunction

    function automatic int cur_col();
        int ph;
        if (m_run == 0) return -1;
        ph = m_t % F;
        if ((ph % P) < BL) return -1;
        return ph / P;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            m_cur = model_edge(bus.enable, bus.wr_en, bus.wr_col, bus.wr_data, bus.swap_req);
            exp_q.push_back(m_cur);
        end
        #1;
        bus.wr_en    = 1'b0;
        bus.swap_req = 1'b0;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic timed_out(string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, awaited event never seen", name);
    endtask

    task automatic wait_col(int col, int budget, string name);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle();
            if (cur_col() == col || (col < 0 && cur_col() >= 0)) found = 1;
        end
        if (!found) timed_out(name);
    endtask

    task automatic wait_fs(int budget, string name);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle();
            if (m_cur.fs) found = 1;
        end
        if (!found) timed_out(name);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({bus.gnd, bus.row, bus.frame_start, bus.swap_ack} !== mon_e) begin
                errors++;
                $display("FAIL scan @%0t: got gnd=%b row=%h fs=%b ack=%b, want gnd=%b row=%h fs=%b ack=%b",
                         $time, bus.gnd, bus.row, bus.frame_start, bus.swap_ack,
                         mon_e.gnd, mon_e.row, mon_e.fs, mon_e.ack);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable   = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_col   = '0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b0;
        model_reset();

        #12;
        chk("reset_gnd",   32'(bus.gnd), 32'(GND_OFF));
        chk("reset_row",   32'(bus.row), 32'd0);
        chk("reset_pulse", 32'({bus.frame_start, bus.swap_ack}), 32'd0);
        rst_n = 1'b1;

        // Plain scan from reset: two full frames.
        bus.enable = 1'b1;
        repeat (2 * F + 2) cycle();

        // Load back[2], request a swap and restart the scan.
        bus.enable = 1'b0;
        cycle();
        bus.wr_en    = 1'b1;
        bus.wr_col   = 3'd2;
        bus.wr_data  = 7'h55;
        bus.swap_req = 1'b1;
        bus.enable   = 1'b1;
        repeat (2 * F + 2) cycle();

        // Drop enable while column 3 is driven, then resume.
        wait_col(3, 2 * F, "wait_col3");
        bus.enable = 1'b0;
        repeat (3) cycle();
        bus.enable = 1'b1;
        repeat (F + 4) cycle();

        // Three requests in one frame, a write on the swap edge, a request in the ack cycle.
        wait_fs(F + 2, "wait_frame_start");
        for (int i = 1; i < F; i++) begin
            if (i == 3 || i == 11 || i == 20) bus.swap_req = 1'b1;
            if (i == 5)  begin bus.wr_en = 1'b1; bus.wr_col = 3'd5; bus.wr_data = 7'h7f; end
            if (i == 13) begin bus.wr_en = 1'b1; bus.wr_col = 3'd7; bus.wr_data = 7'h7f; end
            cycle();
        end
        bus.wr_en   = 1'b1;
        bus.wr_col  = 3'd0;
        bus.wr_data = 7'h2a;
        cycle();
        if (m_cur.ack) bus.swap_req = 1'b1;
        else timed_out("swap_edge_alignment");
        repeat (2 * F + 2) cycle();

        // Randomised traffic.
        for (int i = 0; i < 1200; i++) begin
            if (bus.enable) bus.enable = ($urandom_range(0, 149) != 0);
            else            bus.enable = ($urandom_range(0, 2) == 0);
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_col   = COL_W'($urandom_range(0, 7));
            bus.wr_data  = NROW'($urandom);
            bus.swap_req = ($urandom_range(0, 19) == 0);
            cycle();
        end

        // Reset in the middle of a DRIVE cycle must blank the pins at once.
        bus.enable = 1'b1;
        wait_col(-1, 2 * F, "wait_drive");
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset_gnd", 32'(bus.gnd), 32'(GND_OFF));
        chk("async_reset_row", 32'(bus.row), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (F + 4) cycle();

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
